// File: rtl/datamem_arb_pkg.sv
// ----------------------------------------------------------------------------
// datamem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, port
// index constants and the width of the locked-grant counter.
// ----------------------------------------------------------------------------
package datamem_arb_pkg;

    localparam int LOCK_CNT_W = 8;

    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Combinational 2-way round-robin picker.
//   req[1:0]  in  : per-port request
//   prio      in  : port that wins a tie
//   gnt[1:0]  out : one-hot grant (or zero when nobody requests)
// ----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// ----------------------------------------------------------------------------
// datamem_arbiter
// Shares the single-ported data memory between the CPU load/store port (p0)
// and an auxiliary master (p1). One access per cycle, round-robin on ties,
// bounded locked sequences for atomic read-modify-write, registered read
// return to the winning port.
//   clock, rst_n           : clock, asynchronous active-low reset
//   pN_req/we/lock/addr/wdata : port N request
//   pN_gnt                 : access performed this cycle (combinational)
//   pN_rvalid/rdata        : read return, one cycle after a read grant
//   mem_addr/write/read/wdata, mem_rdata : memory drive and read data
// ----------------------------------------------------------------------------
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LOCK_CNT_W-1:0] LC_MAX = LOCK_CNT_W'(LOCK_MAX);

    arb_state_e            r_state;
    logic                  r_prio;
    logic [LOCK_CNT_W-1:0] r_lcnt;
    logic                  r_p0_rvalid, r_p1_rvalid;
    logic [DATA_W-1:0]     r_p0_rdata, r_p1_rdata;

    arb_state_e            w_state_nxt;
    logic                  w_prio_nxt;
    logic [LOCK_CNT_W-1:0] w_lcnt_nxt;
    logic [LOCK_CNT_W-1:0] w_lcnt_inc;

    logic [1:0] w_req, w_lock, w_we;
    logic [1:0] w_pick, w_gnt_raw, w_gnt;
    logic       w_locked, w_own, w_hold, w_any, w_win;

    assign w_req  = {p1_req,  p0_req};
    assign w_lock = {p1_lock, p0_lock};
    assign w_we   = {p1_we,   p0_we};

    // The picker also serves the release path: when the lock owner drops
    // req its bit is already 0, so only the other port can be picked.
    rr_pick2 u_pick (
        .req  (w_req),
        .prio (r_prio),
        .gnt  (w_pick)
    );

    assign w_locked  = (r_state != ST_IDLE);
    assign w_own     = (r_state == ST_LOCK1);
    assign w_hold    = w_locked && w_req[w_own];
    assign w_gnt_raw = w_hold ? (w_own ? 2'b10 : 2'b01) : w_pick;
    // Gate grants during reset so nothing reaches memory.
    assign w_gnt     = rst_n ? w_gnt_raw : 2'b00;
    assign w_any     = |w_gnt;
    assign w_win     = w_gnt[1];
    assign w_lcnt_inc = r_lcnt + LOCK_CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_lcnt_nxt  = r_lcnt;
        if (w_hold) begin
            if (w_lock[w_own] && (w_lcnt_inc != LC_MAX)) begin
                w_lcnt_nxt = w_lcnt_inc;
            end else begin
                // Final beat or forced release: the other port wins the next tie.
                w_state_nxt = ST_IDLE;
                w_prio_nxt  = ~w_own;
                w_lcnt_nxt  = '0;
            end
        end else begin
            w_state_nxt = ST_IDLE;
            w_lcnt_nxt  = '0;
            if (w_any) begin
                w_prio_nxt = ~w_win;
                if (w_lock[w_win]) begin
                    w_state_nxt = w_win ? ST_LOCK1 : ST_LOCK0;
                    w_lcnt_nxt  = LOCK_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_gnt[0] & ~p0_we;
            r_p1_rvalid <= w_gnt[1] & ~p1_we;
            if (w_gnt[0] & ~p0_we) r_p0_rdata <= mem_rdata;
            if (w_gnt[1] & ~p1_we) r_p1_rdata <= mem_rdata;
        end
    end

    assign p0_gnt    = w_gnt[0];
    assign p1_gnt    = w_gnt[1];
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

    assign mem_addr  = w_any ? (w_win ? p1_addr  : p0_addr)  : '0;
    assign mem_wdata = w_any ? (w_win ? p1_wdata : p0_wdata) : '0;
    assign mem_write = w_any &  w_we[w_win];
    assign mem_read  = w_any & ~w_we[w_win];

endmodule
